// File: rtl/reservation_station_pkg.sv
// reservation_station_pkg: shared widths, opcode encodings and tag-match helper
package reservation_station_pkg;
  localparam int RS_SIZE = 16;
  localparam int ROB_TAG_LEN = 4;
  localparam int OPENUM_LEN = 6;
  localparam int DATA_LEN = 32;
  localparam int ADDR_LEN = 32;
  localparam logic TRUE = 1'b1;
  localparam logic FALSE = 1'b0;
  localparam logic [DATA_LEN-1:0] ZERO_WORD = '0;
  typedef enum logic [OPENUM_LEN-1:0] {
    OPENUM_NOP   = 6'd0,
    OPENUM_ADD   = 6'd1,
    OPENUM_SUB   = 6'd2,
    OPENUM_AND   = 6'd3,
    OPENUM_OR    = 6'd4,
    OPENUM_XOR   = 6'd5,
    OPENUM_SLL   = 6'd6,
    OPENUM_SRL   = 6'd7,
    OPENUM_SRA   = 6'd8,
    OPENUM_SLT   = 6'd9,
    OPENUM_SLTU  = 6'd10,
    OPENUM_ADDI  = 6'd11,
    OPENUM_ANDI  = 6'd12,
    OPENUM_ORI   = 6'd13,
    OPENUM_XORI  = 6'd14,
    OPENUM_SLLI  = 6'd15,
    OPENUM_SRLI  = 6'd16,
    OPENUM_SRAI  = 6'd17,
    OPENUM_SLTI  = 6'd18,
    OPENUM_SLTIU = 6'd19,
    OPENUM_LUI   = 6'd20,
    OPENUM_AUIPC = 6'd21,
    OPENUM_JAL   = 6'd22,
    OPENUM_JALR  = 6'd23,
    OPENUM_BEQ   = 6'd24,
    OPENUM_BNE   = 6'd25,
    OPENUM_BLT   = 6'd26,
    OPENUM_BGE   = 6'd27,
    OPENUM_BLTU  = 6'd28,
    OPENUM_BGEU  = 6'd29
  } openum_e;
  function automatic logic tag_hit(input logic valid, input logic [ROB_TAG_LEN-1:0] a, input logic [ROB_TAG_LEN-1:0] b);
    return valid && (a == b);
  endfunction
endpackage

// File: rtl/rs_lowbit_enc.sv
// rs_lowbit_enc: index of the lowest set bit of a vector plus a found flag
module rs_lowbit_enc #(
  parameter int N = 16
) (
  input  logic [N-1:0]         vec,
  output logic [$clog2(N)-1:0] idx,
  output logic                 found
);
  always_comb begin
    idx = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = i[$clog2(N)-1:0];
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/reservation_station.sv
// reservation_station: Tomasulo ALU/branch station; holds ops until operands
// arrive on the CDBs and issues the lowest ready entry into registered ex_*.
module reservation_station
  import reservation_station_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rdy,
  input  logic                   rollback_flag,
  input  logic                   dsp_ena,
  input  logic [OPENUM_LEN-1:0]  dsp_openum,
  input  logic [DATA_LEN-1:0]    dsp_V1,
  input  logic [DATA_LEN-1:0]    dsp_V2,
  input  logic                   dsp_Q1_pend,
  input  logic                   dsp_Q2_pend,
  input  logic [ROB_TAG_LEN-1:0] dsp_Q1,
  input  logic [ROB_TAG_LEN-1:0] dsp_Q2,
  input  logic [DATA_LEN-1:0]    dsp_imm,
  input  logic [ADDR_LEN-1:0]    dsp_pc,
  input  logic [ROB_TAG_LEN-1:0] dsp_rob_id,
  output logic                   rs_full,
  input  logic                   alu_cdb_valid,
  input  logic [ROB_TAG_LEN-1:0] alu_cdb_rob_id,
  input  logic [DATA_LEN-1:0]    alu_cdb_result,
  input  logic                   lsb_cdb_valid,
  input  logic [ROB_TAG_LEN-1:0] lsb_cdb_rob_id,
  input  logic [DATA_LEN-1:0]    lsb_cdb_result,
  output logic [OPENUM_LEN-1:0]  ex_openum,
  output logic [DATA_LEN-1:0]    ex_V1,
  output logic [DATA_LEN-1:0]    ex_V2,
  output logic [DATA_LEN-1:0]    ex_imm,
  output logic [ADDR_LEN-1:0]    ex_pc,
  output logic [ROB_TAG_LEN-1:0] ex_rob_id
);
  localparam int IW = $clog2(RS_SIZE);
  localparam int CW = IW + 1;
  logic [RS_SIZE-1:0] busy, q1_pend, q2_pend, ready, free_vec;
  logic [OPENUM_LEN-1:0] op [RS_SIZE];
  logic [DATA_LEN-1:0] v1 [RS_SIZE];
  logic [DATA_LEN-1:0] v2 [RS_SIZE];
  logic [DATA_LEN-1:0] imm [RS_SIZE];
  logic [ADDR_LEN-1:0] pc [RS_SIZE];
  logic [ROB_TAG_LEN-1:0] q1 [RS_SIZE];
  logic [ROB_TAG_LEN-1:0] q2 [RS_SIZE];
  logic [ROB_TAG_LEN-1:0] rob_id [RS_SIZE];
  logic [IW-1:0] free_idx, issue_idx;
  logic free_found, issue_found, run, dsp_we;
  logic a1, l1, a2, l2, dsp_p1, dsp_p2;
  logic [DATA_LEN-1:0] dsp_v1, dsp_v2;
  logic [CW-1:0] busy_cnt;
  assign run = rdy && !rollback_flag;
  assign ready = busy & ~q1_pend & ~q2_pend;
  assign free_vec = ~busy;
  assign dsp_we = run && dsp_ena && free_found;
  rs_lowbit_enc #(.N(RS_SIZE)) u_free (.vec(free_vec), .idx(free_idx), .found(free_found));
  rs_lowbit_enc #(.N(RS_SIZE)) u_issue (.vec(ready), .idx(issue_idx), .found(issue_found));
  // Same-cycle CDB bypass into the dispatched entry; ALU wins a double match
  assign a1 = dsp_Q1_pend && tag_hit(alu_cdb_valid, alu_cdb_rob_id, dsp_Q1);
  assign l1 = dsp_Q1_pend && tag_hit(lsb_cdb_valid, lsb_cdb_rob_id, dsp_Q1);
  assign a2 = dsp_Q2_pend && tag_hit(alu_cdb_valid, alu_cdb_rob_id, dsp_Q2);
  assign l2 = dsp_Q2_pend && tag_hit(lsb_cdb_valid, lsb_cdb_rob_id, dsp_Q2);
  assign dsp_v1 = a1 ? alu_cdb_result : l1 ? lsb_cdb_result : dsp_V1;
  assign dsp_v2 = a2 ? alu_cdb_result : l2 ? lsb_cdb_result : dsp_V2;
  assign dsp_p1 = dsp_Q1_pend && !a1 && !l1;
  assign dsp_p2 = dsp_Q2_pend && !a2 && !l2;
  always_comb begin
    busy_cnt = '0;
    for (int i = 0; i < RS_SIZE; i++) busy_cnt = busy_cnt + CW'(busy[i]);
  end
  // One free slot of slack covers the dispatcher's registered decision
  assign rs_full = busy_cnt >= CW'(RS_SIZE - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
      q1_pend <= '0;
      q2_pend <= '0;
    end else if (rdy) begin
      if (rollback_flag) begin
        busy <= '0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy[i] && (tag_hit(alu_cdb_valid, alu_cdb_rob_id, q1[i]) || tag_hit(lsb_cdb_valid, lsb_cdb_rob_id, q1[i])))
            q1_pend[i] <= 1'b0;
          if (busy[i] && (tag_hit(alu_cdb_valid, alu_cdb_rob_id, q2[i]) || tag_hit(lsb_cdb_valid, lsb_cdb_rob_id, q2[i])))
            q2_pend[i] <= 1'b0;
        end
        if (issue_found) busy[issue_idx] <= 1'b0;
        if (dsp_we) begin
          busy[free_idx] <= 1'b1;
          q1_pend[free_idx] <= dsp_p1;
          q2_pend[free_idx] <= dsp_p2;
        end
      end
    end
  end
  // Payload storage needs no reset: it is only read while busy is set
  always_ff @(posedge clk) begin
    if (run) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i] && q1_pend[i])
          v1[i] <= tag_hit(alu_cdb_valid, alu_cdb_rob_id, q1[i]) ? alu_cdb_result :
                   tag_hit(lsb_cdb_valid, lsb_cdb_rob_id, q1[i]) ? lsb_cdb_result : v1[i];
        if (busy[i] && q2_pend[i])
          v2[i] <= tag_hit(alu_cdb_valid, alu_cdb_rob_id, q2[i]) ? alu_cdb_result :
                   tag_hit(lsb_cdb_valid, lsb_cdb_rob_id, q2[i]) ? lsb_cdb_result : v2[i];
      end
      if (dsp_we) begin
        op[free_idx] <= dsp_openum;
        v1[free_idx] <= dsp_v1;
        v2[free_idx] <= dsp_v2;
        q1[free_idx] <= dsp_Q1;
        q2[free_idx] <= dsp_Q2;
        imm[free_idx] <= dsp_imm;
        pc[free_idx] <= dsp_pc;
        rob_id[free_idx] <= dsp_rob_id;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_openum <= OPENUM_NOP;
      ex_V1 <= ZERO_WORD;
      ex_V2 <= ZERO_WORD;
      ex_imm <= ZERO_WORD;
      ex_pc <= '0;
      ex_rob_id <= '0;
    end else if (rdy) begin
      if (rollback_flag || !issue_found) begin
        ex_openum <= OPENUM_NOP;
      end else begin
        ex_openum <= op[issue_idx];
        ex_V1 <= v1[issue_idx];
        ex_V2 <= v2[issue_idx];
        ex_imm <= imm[issue_idx];
        ex_pc <= pc[issue_idx];
        ex_rob_id <= rob_id[issue_idx];
      end
    end
  end
endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: directed vector table plus hand sequences for fill,
// wake ordering, rollback and rdy stall.
module tb_reservation_station;
  import reservation_station_pkg::*;
  logic clk = 1'b0;
  logic rst_n, rdy, rollback_flag, dsp_ena, dsp_Q1_pend, dsp_Q2_pend, rs_full;
  logic [5:0] dsp_openum, ex_openum;
  logic [31:0] dsp_V1, dsp_V2, dsp_imm, dsp_pc, ex_V1, ex_V2, ex_imm, ex_pc;
  logic [3:0] dsp_Q1, dsp_Q2, dsp_rob_id, ex_rob_id, alu_cdb_rob_id, lsb_cdb_rob_id;
  logic alu_cdb_valid, lsb_cdb_valid;
  logic [31:0] alu_cdb_result, lsb_cdb_result;
  int total = 0;
  int bad = 0;
  typedef struct packed {
    logic rdy, rb, ena;
    logic [5:0] op;
    logic [31:0] v1, v2;
    logic q1p;
    logic [3:0] q1;
    logic q2p;
    logic [3:0] q2, rob;
    logic av;
    logic [3:0] at;
    logic [31:0] ar;
    logic lv;
    logic [3:0] lt;
    logic [31:0] lr;
    logic [5:0] eop;
    logic [31:0] ev1, ev2;
    logic [3:0] erob;
    logic efull;
  } vec_t;
  vec_t tab[$];
  vec_t t;
  reservation_station dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .rollback_flag(rollback_flag),
    .dsp_ena(dsp_ena), .dsp_openum(dsp_openum), .dsp_V1(dsp_V1), .dsp_V2(dsp_V2),
    .dsp_Q1_pend(dsp_Q1_pend), .dsp_Q2_pend(dsp_Q2_pend), .dsp_Q1(dsp_Q1), .dsp_Q2(dsp_Q2),
    .dsp_imm(dsp_imm), .dsp_pc(dsp_pc), .dsp_rob_id(dsp_rob_id), .rs_full(rs_full),
    .alu_cdb_valid(alu_cdb_valid), .alu_cdb_rob_id(alu_cdb_rob_id), .alu_cdb_result(alu_cdb_result),
    .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_rob_id(lsb_cdb_rob_id), .lsb_cdb_result(lsb_cdb_result),
    .ex_openum(ex_openum), .ex_V1(ex_V1), .ex_V2(ex_V2), .ex_imm(ex_imm), .ex_pc(ex_pc),
    .ex_rob_id(ex_rob_id)
  );
  always #5 clk = ~clk;
  function automatic vec_t idle();
    vec_t r;
    r = '0;
    r.rdy = 1'b1;
    return r;
  endfunction
  function automatic vec_t d(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic p1, input logic [3:0] q1, input logic p2, input logic [3:0] q2,
                             input logic [3:0] rob);
    vec_t r;
    r = idle();
    r.ena = 1'b1; r.op = op; r.v1 = a; r.v2 = b;
    r.q1p = p1; r.q1 = q1; r.q2p = p2; r.q2 = q2; r.rob = rob;
    return r;
  endfunction
  function automatic vec_t cdb(input vec_t r, input logic av, input logic [3:0] at, input logic [31:0] ar,
                               input logic lv, input logic [3:0] lt, input logic [31:0] lr);
    vec_t o;
    o = r;
    o.av = av; o.at = at; o.ar = ar; o.lv = lv; o.lt = lt; o.lr = lr;
    return o;
  endfunction
  function automatic vec_t e(input vec_t r, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [3:0] rob, input logic full);
    vec_t o;
    o = r;
    o.eop = op; o.ev1 = a; o.ev2 = b; o.erob = rob; o.efull = full;
    return o;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step(input vec_t s, input string name);
    rdy = s.rdy; rollback_flag = s.rb; dsp_ena = s.ena; dsp_openum = s.op;
    dsp_V1 = s.v1; dsp_V2 = s.v2; dsp_Q1_pend = s.q1p; dsp_Q1 = s.q1;
    dsp_Q2_pend = s.q2p; dsp_Q2 = s.q2; dsp_rob_id = s.rob;
    dsp_pc = 32'h1000 + {26'd0, s.rob, 2'b00};
    dsp_imm = 32'h100 + {28'd0, s.rob};
    alu_cdb_valid = s.av; alu_cdb_rob_id = s.at; alu_cdb_result = s.ar;
    lsb_cdb_valid = s.lv; lsb_cdb_rob_id = s.lt; lsb_cdb_result = s.lr;
    @(posedge clk);
    #1;
    chk({name, " op"}, {26'd0, ex_openum}, {26'd0, s.eop});
    chk({name, " v1"}, ex_V1, s.ev1);
    chk({name, " v2"}, ex_V2, s.ev2);
    chk({name, " rob"}, {28'd0, ex_rob_id}, {28'd0, s.erob});
    chk({name, " full"}, {31'd0, rs_full}, {31'd0, s.efull});
    if (s.eop != OPENUM_NOP) begin
      chk({name, " pc"}, ex_pc, 32'h1000 + {26'd0, s.erob, 2'b00});
      chk({name, " imm"}, ex_imm, 32'h100 + {28'd0, s.erob});
    end
  endtask
  initial begin
    rst_n = 1'b0;
    t = idle();
    rdy = 1'b1; rollback_flag = 1'b0; dsp_ena = 1'b0; dsp_openum = '0;
    dsp_V1 = '0; dsp_V2 = '0; dsp_Q1_pend = 1'b0; dsp_Q2_pend = 1'b0; dsp_Q1 = '0; dsp_Q2 = '0;
    dsp_imm = '0; dsp_pc = '0; dsp_rob_id = '0;
    alu_cdb_valid = 1'b0; alu_cdb_rob_id = '0; alu_cdb_result = '0;
    lsb_cdb_valid = 1'b0; lsb_cdb_rob_id = '0; lsb_cdb_result = '0;
    #12 rst_n = 1'b1;
    chk("rst op", {26'd0, ex_openum}, 32'd0);
    chk("rst v1", ex_V1, 32'd0);
    chk("rst v2", ex_V2, 32'd0);
    chk("rst imm", ex_imm, 32'd0);
    chk("rst pc", ex_pc, 32'd0);
    chk("rst rob", {28'd0, ex_rob_id}, 32'd0);
    chk("rst full", {31'd0, rs_full}, 32'd0);
    tab.push_back(e(d(OPENUM_ADD, 5, 7, 0, 0, 0, 0, 3), OPENUM_NOP, 0, 0, 0, 0));
    tab.push_back(e(idle(), OPENUM_ADD, 5, 7, 3, 0));
    tab.push_back(e(idle(), OPENUM_NOP, 5, 7, 3, 0));
    tab.push_back(e(d(OPENUM_SUB, 0, 9, 1, 2, 0, 0, 4), OPENUM_NOP, 5, 7, 3, 0));
    tab.push_back(e(idle(), OPENUM_NOP, 5, 7, 3, 0));
    tab.push_back(e(cdb(idle(), 1, 2, 32'h10, 0, 0, 0), OPENUM_NOP, 5, 7, 3, 0));
    tab.push_back(e(idle(), OPENUM_SUB, 32'h10, 9, 4, 0));
    tab.push_back(e(cdb(d(OPENUM_OR, 32'h11, 0, 0, 0, 1, 6, 5), 0, 0, 0, 1, 6, 32'hABCD), OPENUM_NOP, 32'h10, 9, 4, 0));
    tab.push_back(e(idle(), OPENUM_OR, 32'h11, 32'hABCD, 5, 0));
    tab.push_back(e(cdb(d(OPENUM_XOR, 0, 1, 1, 7, 0, 0, 6), 1, 7, 32'h77, 1, 7, 32'h88), OPENUM_NOP, 32'h11, 32'hABCD, 5, 0));
    tab.push_back(e(idle(), OPENUM_XOR, 32'h77, 1, 6, 0));
    tab.push_back(e(d(OPENUM_AND, 0, 2, 1, 8, 0, 0, 7), OPENUM_NOP, 32'h77, 1, 6, 0));
    tab.push_back(e(cdb(idle(), 1, 9, 32'h99, 0, 0, 0), OPENUM_NOP, 32'h77, 1, 6, 0));
    tab.push_back(e(cdb(idle(), 0, 0, 0, 1, 8, 32'h42), OPENUM_NOP, 32'h77, 1, 6, 0));
    tab.push_back(e(idle(), OPENUM_AND, 32'h42, 2, 7, 0));
    tab.push_back(e(idle(), OPENUM_NOP, 32'h42, 2, 7, 0));
    tab.push_back(e(d(OPENUM_BEQ, 0, 0, 1, 11, 1, 12, 8), OPENUM_NOP, 32'h42, 2, 7, 0));
    tab.push_back(e(cdb(idle(), 1, 11, 32'h1111, 0, 0, 0), OPENUM_NOP, 32'h42, 2, 7, 0));
    tab.push_back(e(idle(), OPENUM_NOP, 32'h42, 2, 7, 0));
    tab.push_back(e(cdb(idle(), 0, 0, 0, 1, 12, 32'h2222), OPENUM_NOP, 32'h42, 2, 7, 0));
    tab.push_back(e(idle(), OPENUM_BEQ, 32'h1111, 32'h2222, 8, 0));
    tab.push_back(e(idle(), OPENUM_NOP, 32'h1111, 32'h2222, 8, 0));
    for (int k = 0; k < tab.size(); k++) step(tab[k], $sformatf("t%0d", k));
    // Fill 15 pending entries; rs_full rises only when a single slot remains
    for (int i = 0; i < 15; i++)
      step(e(d(OPENUM_ADD, 0, 32'h30 + i, 1, 4'(i), 0, 0, 4'(i)), OPENUM_NOP, 32'h1111, 32'h2222, 8, i == 14),
           $sformatf("fill%0d", i));
    step(e(cdb(idle(), 1, 4, 32'h44, 1, 9, 32'h99), OPENUM_NOP, 32'h1111, 32'h2222, 8, 1), "wake");
    step(e(idle(), OPENUM_ADD, 32'h44, 32'h34, 4, 0), "iss4");
    step(e(idle(), OPENUM_ADD, 32'h99, 32'h39, 9, 0), "iss9");
    step(e(idle(), OPENUM_NOP, 32'h99, 32'h39, 9, 0), "drain");
    t = e(idle(), OPENUM_NOP, 32'h99, 32'h39, 9, 0);
    t.rb = 1'b1;
    step(t, "rb1");
    step(e(cdb(idle(), 1, 0, 32'h5, 0, 0, 0), OPENUM_NOP, 32'h99, 32'h39, 9, 0), "rb1 wake");
    step(e(idle(), OPENUM_NOP, 32'h99, 32'h39, 9, 0), "rb1 empty");
    for (int i = 0; i < 3; i++)
      step(e(d(OPENUM_SUB, 0, 32'h50 + i, 1, 1, 0, 0, 4'(i + 1)), OPENUM_NOP, 32'h99, 32'h39, 9, 0),
           $sformatf("rb2 d%0d", i));
    step(e(cdb(idle(), 1, 1, 32'h5, 0, 0, 0), OPENUM_NOP, 32'h99, 32'h39, 9, 0), "rb2 wake");
    t = e(d(OPENUM_ADD, 1, 1, 0, 0, 0, 0, 12), OPENUM_NOP, 32'h99, 32'h39, 9, 0);
    t.rb = 1'b1;
    step(t, "rb2");
    step(e(idle(), OPENUM_NOP, 32'h99, 32'h39, 9, 0), "rb2 post0");
    step(e(idle(), OPENUM_NOP, 32'h99, 32'h39, 9, 0), "rb2 post1");
    step(e(d(OPENUM_ADD, 32'h21, 32'h22, 0, 0, 0, 0, 10), OPENUM_NOP, 32'h99, 32'h39, 9, 0), "stall d0");
    step(e(d(OPENUM_OR, 32'h31, 32'h32, 0, 0, 0, 0, 11), OPENUM_ADD, 32'h21, 32'h22, 10, 0), "stall d1");
    for (int i = 0; i < 3; i++) begin
      t = e(idle(), OPENUM_ADD, 32'h21, 32'h22, 10, 0);
      t.rdy = 1'b0;
      step(t, $sformatf("stall%0d", i));
    end
    step(e(idle(), OPENUM_OR, 32'h31, 32'h32, 11, 0), "resume");
    step(e(idle(), OPENUM_NOP, 32'h31, 32'h32, 11, 0), "resume idle");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Tomasulo reservation station for ALU/branch ops, directly upstream of the execution unit.
- Accepts decoded instructions from the dispatcher and holds them until both source operands are available.
- Snoops the ALU and LSB common data buses (CDBs) for operand values.
- Issues at most one ready entry per cycle, as a registered operand bundle, to the combinational execute stage.

Parameters:
- RS_SIZE, 16, number of entries (power of two, ≥2).
- ROB_TAG_LEN, 4, width of a ROB index / rename tag.
- OPENUM_LEN, 6, width of the internal opcode enum.
- DATA_LEN, 32, operand/result width.
- ADDR_LEN, 32, PC width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rdy  in  1  global enable; when low, all state and outputs hold.
- rollback_flag  in  1  mispredict flush from ROB.
- dsp_ena  in  1  dispatch valid this cycle.
- dsp_openum  in  OPENUM_LEN  opcode.
- dsp_V1, dsp_V2  in  DATA_LEN  operand values (meaningful when not pending).
- dsp_Q1_pend, dsp_Q2_pend  in  1  operand still waiting on a tag.
- dsp_Q1, dsp_Q2  in  ROB_TAG_LEN  producer ROB tags.
- dsp_imm  in  DATA_LEN  immediate.
- dsp_pc  in  ADDR_LEN  instruction PC.
- dsp_rob_id  in  ROB_TAG_LEN  destination ROB entry.
- rs_full  out  1  dispatcher must not dispatch next cycle.
- alu_cdb_valid  in  1  ALU result broadcast valid.
- alu_cdb_rob_id  in  ROB_TAG_LEN  ALU result tag.
- alu_cdb_result  in  DATA_LEN  ALU result value.
- lsb_cdb_valid  in  1  LSB result broadcast valid.
- lsb_cdb_rob_id  in  ROB_TAG_LEN  LSB result tag.
- lsb_cdb_result  in  DATA_LEN  LSB result value.
- ex_openum  out  OPENUM_LEN  issued opcode; OPENUM_NOP when idle.
- ex_V1, ex_V2, ex_imm  out  DATA_LEN  issued operands.
- ex_pc  out  ADDR_LEN  issued PC.
- ex_rob_id  out  ROB_TAG_LEN  issued destination tag.

Behaviour:
- Per-entry state: busy, openum, V1, V2, Q1_pend, Q2_pend, Q1, Q2, imm, pc, rob_id.
- Reset (async, rst_n=0):
  - All busy=0.
  - ex_openum=OPENUM_NOP.
  - ex_V1/ex_V2/ex_imm/ex_pc/ex_rob_id=0.
  - rs_full=0.
- rdy=0: nothing changes, including CDB capture; the CDB is required idle.
- Priority per rising edge with rdy=1: rollback > (issue ∥ dispatch ∥ snoop).
- Rollback:
  - All busy cleared.
  - ex_openum=NOP at that edge; other ex_* outputs hold.
  - The same-cycle dispatch is dropped.
- Ready: entry busy && !Q1_pend && !Q2_pend, evaluated on registered state only.
- Issue:
  - The lowest-index ready entry is copied to the ex_* registers and its busy is cleared.
  - With no ready entry, ex_openum=NOP and the other ex_* outputs hold.
  - ex_* are valid for exactly one cycle per issue.
- Dispatch: with dsp_ena=1, fields are written to the lowest-index entry with busy=0 in registered state. A slot freed by issue in the same cycle is not reused until the next cycle.
- Dispatch bypass: if dsp_Qx_pend=1 and a valid CDB in the same cycle carries tag == dsp_Qx, the entry stores the CDB value with pend=0.
- Snoop: for every busy entry and each pending operand, a tag match on a valid CDB captures the result and clears pend.
- Both CDBs matching the same tag is illegal; if it occurs, ALU wins.
- Latency:
  - Ready dispatch at edge N → ex_* valid after edge N+1 (minimum 1 cycle).
  - Operand woken at edge N → earliest issue at edge N+1.
- rs_full: combinational from registered busy vector. Asserted when free entries ≤ 1, giving one cycle of slack for the dispatcher's registered decision.
- dsp_ena with zero free entries is a protocol violation: dispatch is dropped and no entry is corrupted.
- Widths:
  - Busy count is $clog2(RS_SIZE)+1 bits.
  - Tag compare is exact ROB_TAG_LEN equality.
  - No arithmetic on data.

Decomposition:
- Shared defines file holds OPENUM_* values (incl. OPENUM_NOP), DATA_LEN, ADDR_LEN, ROB_TAG_LEN, RS_SIZE, TRUE/FALSE, ZERO_WORD.
- One natural sub-module: rs_lowbit_enc (RS_SIZE-bit vector → index + found flag). It is instantiated twice: free-slot select and ready select.

Test Plan:
- Reset then dispatch ADD, V1=5, V2=7, both ready, rob_id=3 → one cycle later ex_openum=ADD, ex_V1=5, ex_V2=7, ex_rob_id=3; the next cycle returns NOP.
- Dispatch SUB with Q1_pend, Q1=2; two cycles later alu_cdb_valid, rob_id=2, result=0x10 → issue the following cycle with ex_V1=0x10.
- Dispatch with Q2_pend, Q2=6 while lsb_cdb broadcasts tag 6, value 0xABCD in the same cycle → issues next cycle with ex_V2=0xABCD.
- Fill 15 entries, all pending → rs_full=1. Then wake entries 4 and 9 on the same edge → entry 4 issues first and entry 9 the next cycle.
- Three ready entries resident plus rollback_flag asserted → ex_openum=NOP, rs_full=0, no further issues.
- rdy low for 3 cycles with a ready entry → ex_* frozen; issue occurs on the first cycle after rdy returns high.
